// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg: shared constants for the DES round function f(R, K).
//   R_W / K_W : half-block and round-key widths
//   E_TABLE   : expansion table, FIPS 46-3 1-based bit numbers (48 entries)
//   P_TABLE   : permutation table, FIPS 46-3 1-based bit numbers (32 entries)
//   SBOX      : S1..S8, each 64 entries stored row-major (row*16 + column)
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int R_W = 32;
  localparam int K_W = 48;

  localparam int E_TABLE [0:47] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TABLE [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int SBOX [0:7][0:63] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

endpackage

// File: rtl/des_sbox.sv
// -----------------------------------------------------------------------------
// des_sbox: one DES S-box, purely combinational table lookup.
//   SBOX_IDX : 0..7 selects S1..S8
//   i_bits   : 6-bit group, i_bits[5] = b1 ... i_bits[0] = b6
//   o_val    : 4-bit substitution result
// -----------------------------------------------------------------------------
module des_sbox
  import des_pkg::*;
#(
  parameter int SBOX_IDX = 0
) (
  input  logic [5:0] i_bits,
  output logic [3:0] o_val
);

  logic [5:0] w_idx;

  // Row {b1,b6} is the upper two index bits, column b2..b5 the lower four.
  assign w_idx = {i_bits[5], i_bits[0], i_bits[4:1]};
  assign o_val = SBOX[SBOX_IDX][w_idx][3:0];

endmodule

// File: rtl/des_f_function.sv
// -----------------------------------------------------------------------------
// des_f_function: DES round function f(R, K) = P(S(E(R) xor K)) with a
// registered output and valid flag. DES bit n lives at vector index (width-n).
//   clk, rst (async, active high)
//   in_valid, R_in[31:0], round_key[47:0] : input transaction
//   out_valid, f_out[31:0]                : registered result
// Build option DES_F_PIPE2_EN: adds a register after the key mix (X plus
// valid), giving 2-cycle latency; otherwise latency is 1 cycle.
// -----------------------------------------------------------------------------
module des_f_function
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [R_W-1:0]   R_in,
  input  logic [K_W-1:0]   round_key,
  output logic             out_valid,
  output logic [R_W-1:0]   f_out
);

  logic [K_W-1:0] w_e;
  logic [K_W-1:0] w_x;
  logic [K_W-1:0] w_sbox_in;
  logic           w_stage_valid;
  logic [R_W-1:0] w_s;
  logic [R_W-1:0] w_f;
  logic [R_W-1:0] r_f;
  logic           r_valid;

  // Expansion: E bit i (1-based) takes R bit E_TABLE[i].
  always_comb begin
    w_e = '0;
    for (int i = 0; i < K_W; i++) begin
      w_e[K_W-1-i] = R_in[R_W-E_TABLE[i]];
    end
  end

  assign w_x = w_e ^ round_key;

`ifdef DES_F_PIPE2_EN
  logic [K_W-1:0] r_x;
  logic           r_x_valid;

  // Intermediate stage: X and its valid bit travel together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_x_valid <= 1'b0;
    end else begin
      r_x_valid <= in_valid;
      if (in_valid) begin
        r_x <= w_x;
      end
    end
  end

  assign w_sbox_in     = r_x;
  assign w_stage_valid = r_x_valid;
`else
  assign w_sbox_in     = w_x;
  assign w_stage_valid = in_valid;
`endif

  // Eight S-boxes, group j taken MSB-first, outputs concatenated MSB-first.
  for (genvar j = 0; j < 8; j++) begin : g_sbox
    des_sbox #(.SBOX_IDX(j)) u_sbox (
      .i_bits (w_sbox_in[K_W-1-6*j -: 6]),
      .o_val  (w_s[R_W-1-4*j -: 4])
    );
  end

  // Permutation: f bit i (1-based) takes S bit P_TABLE[i].
  always_comb begin
    w_f = '0;
    for (int i = 0; i < R_W; i++) begin
      w_f[R_W-1-i] = w_s[R_W-P_TABLE[i]];
    end
  end

  // Output register: capture on valid, hold data otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f     <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_stage_valid;
      if (w_stage_valid) begin
        r_f <= w_f;
      end
    end
  end

  assign f_out     = r_f;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_des_f_function.sv
// -----------------------------------------------------------------------------
// tb_des_f_function: directed-vector bench for des_f_function. Works for both
// the default build and DES_F_PIPE2_EN (latency LAT adapts).
// -----------------------------------------------------------------------------
module tb_des_f_function;

`ifdef DES_F_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] R_in;
  logic [47:0] round_key;
  logic        out_valid;
  logic [31:0] f_out;

  int n_tests;
  int n_fail;

  des_f_function dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .R_in      (R_in),
    .round_key (round_key),
    .out_valid (out_valid),
    .f_out     (f_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Streaming and gap vectors: {R, K, expected f}
  logic [31:0] s_r [0:3] = '{32'hCBC83781, 32'hE11D7D69, 32'h36796115, 32'hB49A86FC};
  logic [47:0] s_k [0:3] = '{48'h42B97B7BD049, 48'hB3C5EA2D1302, 48'h1FA810982547, 48'h6DDDF3B690D2};
  logic [31:0] s_f [0:3] = '{32'hFB06A82D, 32'hE818663E, 32'h1FD9D69F, 32'hB8FFA41A};
  logic [31:0] g_r [0:4] = '{32'hAAEAFCE9, 32'hD0C3593F, 32'hE4671F1F, 32'h89D0194D, 32'h9ED0095F};
  logic [47:0] g_k [0:4] = '{48'h1B1064F3B537, 48'h8B22B573F739, 48'h3AB4EF1A434E, 48'h53C38C158831, 48'h5B5D33FEE25A};
  logic [31:0] g_f [0:4] = '{32'hC1906276, 32'h3501B522, 32'h8DFEAC29, 32'hF8D01024, 32'hD9F630B0};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single transaction, then one idle cycle checking the held value.
  task automatic run_one(input string tag, input logic [31:0] r, input logic [47:0] k,
                         input logic [31:0] exp);
    R_in = r; round_key = k; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    R_in = ~r; round_key = ~k;
    for (int i = 1; i < LAT; i++) step();
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_val({tag, "_data"}, f_out, exp);
    step();
    check_val({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_hold"}, f_out, exp);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b1;
    R_in = 32'hDFB5FE6D; round_key = 48'h41930546E942;
    // Reset state, with in_valid asserted that must be discarded.
    #1;
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_data", f_out, 32'h0);
    step(); step();
    check_val("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_hold_data", f_out, 32'h0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    step();
    for (int i = 1; i < LAT; i++) step();
    check_val("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // Vector 1.
    run_one("vec1", 32'hDFB5FE6D, 48'h41930546E942, 32'hD198714F);

    // Back-to-back streaming.
    for (int c = 0; c < 4 + LAT - 1; c++) begin
      if (c < 4) begin
        R_in = s_r[c]; round_key = s_k[c]; in_valid = 1'b1;
      end else begin
        R_in = 32'h0; round_key = 48'h0; in_valid = 1'b0;
      end
      step();
      if (c >= LAT - 1) begin
        check_val($sformatf("stream%0d_valid", c - LAT + 1), {31'd0, out_valid}, 32'd1);
        check_val($sformatf("stream%0d_data", c - LAT + 1), f_out, s_f[c - LAT + 1]);
      end
    end
    in_valid = 1'b0;
    step();
    check_val("stream_end_valid", {31'd0, out_valid}, 32'd0);

    // Vectors with gaps between them.
    for (int g = 0; g < 5; g++) begin
      run_one($sformatf("gap%0d", g), g_r[g], g_k[g], g_f[g]);
      step();
    end

    // Idle with changing inputs: output must not move.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      R_in = $urandom; round_key = {$urandom, $urandom};
      step();
      check_val($sformatf("idle%0d_valid", i), {31'd0, out_valid}, 32'd0);
      check_val($sformatf("idle%0d_data", i), f_out, 32'hD9F630B0);
    end

    // Mid-stream reset: clears at once, nothing captured while held.
    R_in = s_r[0]; round_key = s_k[0]; in_valid = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_data", f_out, 32'h0);
    step(); step();
    check_val("mid_rst_hold_data", f_out, 32'h0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      step();
      check_val($sformatf("mid_rst_flush%0d_valid", i), {31'd0, out_valid}, 32'd0);
      check_val($sformatf("mid_rst_flush%0d_data", i), f_out, 32'h0);
    end

    // Normal operation resumes after reset.
    run_one("after_rst", s_r[1], s_k[1], s_f[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
